tap_sample_sched: RTL and testbench

- Frame-based sampling scheduler for a shared serial delay line.
- One internal shift register delays input `din`. A frame counter sequences NSLOT programmable capture slots. At each slot, one configured tap of the line is latched into a hit bit.
- At frame end the block reports the per-slot hits, their AND (coincidence) and their OR (any), plus a one-cycle done pulse.
- Sits after the delay/OR-combine stage and replaces hard-wired slot comparisons and fixed tap ANDs with a configurable table.

---
 rtl/tap_sample_sched.sv | 168 ++++++++++++++++
 tb/tb_tap_sample_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_sample_sched.sv
// tap_sample_sched: frame-based sampling scheduler for a shared serial delay line.
// A DEPTH-long shift register delays din_i; a frame counter walks FRAME_LEN cycles
// and each of NSLOT table entries latches one tap of the line into a hit bit when
// the counter equals its programmed slot. At frame end done_o pulses and the hits,
// their AND (coinc_o) and their OR (any_o) are presented until the next frame starts.
// Optional build macro: TAP_SCHED_AUTO_RERUN_EN -- when defined, start_i seen in
// DONE launches the next frame directly (period FRAME_LEN+1 instead of FRAME_LEN+2).
module tap_sample_sched #(
  parameter int DEPTH     = 20,
  parameter int NSLOT     = 3,
  parameter int FRAME_LEN = 19,
  parameter int CW        = 5,
  parameter int AW        = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             din_i,
  input  logic             start_i,
  input  logic             cfg_we_i,
  input  logic [AW-1:0]    cfg_addr_i,
  input  logic [CW-1:0]    cfg_slot_i,
  input  logic [CW-1:0]    cfg_tap_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CW-1:0]    cnt_o,
  output logic [NSLOT-1:0] hits_o,
  output logic             coinc_o,
  output logic             any_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Last frame cycle; the capture at this count still happens before leaving RUN.
  localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_LEN - 1);
  // Tap clamp bounds; compared one bit wider so DEPTH == 2^CW cannot wrap to zero.
  localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] TAP_MAX   = CW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] line_q;
  logic [CW-1:0]    tap_clamped;
  logic             cfg_en;
  logic             hits_clr;
  logic             cap_en;
  logic [NSLOT-1:0] hits_w;

  // Out-of-range taps are folded onto the oldest tap at write time, so the
  // capture path never has to index past the end of the line.
  assign tap_clamped = ({1'b0, cfg_tap_i} >= DEPTH_EXT) ? TAP_MAX : cfg_tap_i;

  // Delay line: bit k holds din_i delayed k+1 clocks; it runs in every state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= '0;
    end else begin
      line_q <= {line_q[DEPTH-2:0], din_i};
    end
  end

  // State and frame-counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: table writes only in IDLE, captures only in RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cfg_en   = 1'b0;
    hits_clr = 1'b0;
    cap_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        // The write lands on the same edge that starts a frame, so a
        // simultaneous write/start uses the freshly written entry.
        cfg_en = cfg_we_i;
        if (start_i) begin
          state_d  = ST_RUN;
          hits_clr = 1'b1;
        end
      end
      ST_RUN: begin
        cap_en = 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
`ifdef TAP_SCHED_AUTO_RERUN_EN
        // Back-to-back frames: skip IDLE when another frame is already requested.
        if (start_i) begin
          state_d  = ST_RUN;
          hits_clr = 1'b1;
        end
`else
        // DONE always drains to IDLE; start_i is only honoured there.
`endif
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // One table entry and one hit bit per slot.
  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      logic [CW-1:0] slot_q;
      logic [CW-1:0] tap_q;
      logic          hit_q;
      logic          addr_match;

      // Addresses at or above NSLOT match no entry and are dropped.
      assign addr_match = (cfg_addr_i == AW'(gi));

      // Table entry: frozen outside IDLE so a running frame sees a stable table.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          slot_q <= '0;
          tap_q  <= '0;
        end else if (cfg_en && addr_match) begin
          slot_q <= cfg_slot_i;
          tap_q  <= tap_clamped;
        end
      end

      // Hit capture: a slot count beyond the frame never matches, leaving 0.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          hit_q <= 1'b0;
        end else if (hits_clr) begin
          hit_q <= 1'b0;
        end else if (cap_en && (cnt_q == slot_q)) begin
          hit_q <= line_q[tap_q];
        end
      end

      assign hits_w[gi] = hit_q;
    end
  endgenerate

  assign busy_o  = (state_q == ST_RUN);
  assign done_o  = (state_q == ST_DONE);
  assign cnt_o   = cnt_q;
  assign hits_o  = hits_w;
  assign coinc_o = &hits_w;
  assign any_o   = |hits_w;

endmodule

// File: tb/tb_tap_sample_sched.sv
// Directed bench for tap_sample_sched with default parameters
// (DEPTH=20, NSLOT=3, FRAME_LEN=19).
module tb_tap_sample_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       start;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [4:0] cfg_slot;
  logic [4:0] cfg_tap;
  logic       busy;
  logic       done;
  logic [4:0] cnt;
  logic [2:0] hits;
  logic       coinc;
  logic       any;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef TAP_SCHED_AUTO_RERUN_EN
  localparam int EXP_PERIOD = 20;
  localparam int EXP_LOWC   = 1;
`else
  localparam int EXP_PERIOD = 21;
  localparam int EXP_LOWC   = 2;
`endif

  tap_sample_sched dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .din_i     (din),
    .start_i   (start),
    .cfg_we_i  (cfg_we),
    .cfg_addr_i(cfg_addr),
    .cfg_slot_i(cfg_slot),
    .cfg_tap_i (cfg_tap),
    .busy_o    (busy),
    .done_o    (done),
    .cnt_o     (cnt),
    .hits_o    (hits),
    .coinc_o   (coinc),
    .any_o     (any)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [4:0] s, input logic [4:0] t);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_slot = s;
    cfg_tap  = t;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  // Start a frame from IDLE; returns in the first RUN cycle (cnt = 0).
  task automatic launch(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy_rise"}, 32'(busy), 32'd1);
    chk({tag, " cnt0"}, 32'(cnt), 32'd0);
  endtask

  // Wait for the done pulse, check results, then step back to IDLE.
  task automatic finish_frame(input string tag, input logic [2:0] exp_hits, input int exp_lat);
    int lat;
    wait_done(lat);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, " cnt_in_done"}, 32'(cnt), 32'd0);
    chk({tag, " hits"}, 32'(hits), 32'(exp_hits));
    chk({tag, " coinc"}, 32'(coinc), 32'(&exp_hits));
    chk({tag, " any"}, 32'(any), 32'(|exp_hits));
    tick();
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, " hits_hold"}, 32'(hits), 32'(exp_hits));
  endtask

  // Put a single din=1 sample exactly 19 edges before the start edge,
  // so tap 19 holds it at the cnt=0 capture edge.
  task automatic din_pulse_lead19();
    din = 1'b0;
    repeat (30) tick();
    din = 1'b1;
    tick();
    din = 1'b0;
    repeat (18) tick();
  endtask

  initial begin
    int p;
    int lowc;
    int ndone;
    int lat;

    rst_n    = 1'b0;
    din      = 1'b0;
    start    = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_slot = '0;
    cfg_tap  = '0;

    // Reset values
    #2;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst cnt", 32'(cnt), 32'd0);
    chk("rst hits", 32'(hits), 32'd0);
    chk("rst coinc", 32'(coinc), 32'd0);
    chk("rst any", 32'(any), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // T1: single din pulse in the first RUN cycle reaches only slot0 (cnt 1, tap 0)
    cfg_write(2'd0, 5'd1, 5'd0);
    cfg_write(2'd1, 5'd2, 5'd2);
    cfg_write(2'd2, 5'd5, 5'd8);
    launch("t1");
    din = 1'b1;
    tick();
    din = 1'b0;
    chk("t1 cnt1", 32'(cnt), 32'd1);
    finish_frame("t1", 3'b001, 18);

    // T2a: all slots at cycle 18, taps 19/18/14, din held high
    cfg_write(2'd0, 5'd18, 5'd19);
    cfg_write(2'd1, 5'd18, 5'd18);
    cfg_write(2'd2, 5'd18, 5'd14);
    din = 1'b1;
    repeat (30) tick();
    launch("t2a");
    finish_frame("t2a", 3'b111, 19);

    // T3: write during RUN is ignored for the running frame
    launch("t3run");
    repeat (3) tick();
    chk("t3run cnt3", 32'(cnt), 32'd3);
    cfg_we   = 1'b1;
    cfg_addr = 2'd0;
    cfg_slot = 5'd20;
    cfg_tap  = 5'd0;
    tick();
    cfg_we   = 1'b0;
    finish_frame("t3run", 3'b111, 15);

    // T3b: same write in IDLE takes effect; slot 20 never matches
    cfg_write(2'd0, 5'd20, 5'd0);
    launch("t3idle");
    finish_frame("t3idle", 3'b110, 19);

    // T3c: write and start in the same cycle, frame uses the new entry
    cfg_we   = 1'b1;
    cfg_addr = 2'd0;
    cfg_slot = 5'd18;
    cfg_tap  = 5'd19;
    launch("t3same");
    cfg_we   = 1'b0;
    finish_frame("t3same", 3'b111, 19);

    // T2b: din low -> nothing captured
    din = 1'b0;
    repeat (30) tick();
    launch("t2b");
    finish_frame("t2b", 3'b000, 19);

    // T4: tap 25 clamps to 19; address 3 must not touch any entry
    cfg_write(2'd0, 5'd0, 5'd25);
    cfg_write(2'd3, 5'd0, 5'd19);
    din_pulse_lead19();
    launch("t4");
    finish_frame("t4", 3'b001, 19);

    // T5: reset at cnt 7 aborts the frame
    din_pulse_lead19();
    launch("t5");
    repeat (7) tick();
    chk("t5 cnt7", 32'(cnt), 32'd7);
    chk("t5 hits_pre", 32'(hits), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5 rst cnt", 32'(cnt), 32'd0);
    chk("t5 rst busy", 32'(busy), 32'd0);
    chk("t5 rst done", 32'(done), 32'd0);
    chk("t5 rst hits", 32'(hits), 32'd0);
    chk("t5 rst any", 32'(any), 32'd0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("t5 no_done", 32'(ndone), 32'd0);
    chk("t5 idle", 32'(busy), 32'd0);
    // Table was reset to slot 0 / tap 0: every slot samples din at the start edge
    din = 1'b1;
    launch("t5fresh");
    din = 1'b0;
    finish_frame("t5fresh", 3'b111, 19);

    // T6: start held high, measure done period and busy-low cycles
    start = 1'b1;
    wait_done(lat);
    chk("t6 first_done", 32'(done), 32'd1);
    lowc = (busy === 1'b0) ? 1 : 0;
    p = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      p = i;
      if (done === 1'b1) break;
      if (busy === 1'b0) lowc++;
    end
    chk("t6 period", 32'(p), 32'(EXP_PERIOD));
    chk("t6 busy_low", 32'(lowc), 32'(EXP_LOWC));
    start = 1'b0;
    tick();
    tick();
    chk("t6 end busy", 32'(busy), 32'd0);
    chk("t6 end done", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
